// File: rtl/processor_pkg.sv
// Shared processor types: opcode encoding, fetch FSM states and instruction field positions.
package processor_pkg;

  localparam int unsigned OPC_W   = 3;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned OPC_MSB = 8;
  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned RX_MSB  = 5;
  localparam int unsigned RX_LSB  = 3;
  localparam int unsigned RY_MSB  = 2;
  localparam int unsigned RY_LSB  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_MOV  = 3'b000,
    OP_MOVI = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_NONE = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    IMM_REQ,
    IMM_CAP,
    ISSUE,
    WAIT,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter: cleared by reset, increments on request, wraps silently at 2^ADDR_W.
module program_counter #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch/decode/issue sequencer feeding the control unit.
// Define INSTRUCTION_FETCH_HALT_OPCODE_EN to make opcode 3'b111 halt instead of being skipped.
module instruction_fetch
  import processor_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              done,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [2:0]        opcode,
  output logic [2:0]        reg_x,
  output logic [2:0]        reg_y,
  output logic [DATA_W-1:0] immediate,
  output logic              busy
`ifdef INSTRUCTION_FETCH_HALT_OPCODE_EN
  ,
  output logic              halted
`endif
);

  fetch_state_e      state;
  fetch_state_e      state_d;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              ir_load;
  logic              imm_load;
  logic [OPC_W-1:0]  rdata_op;
  logic [OPC_W-1:0]  issue_op;

  program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clock (clock),
    .reset (reset),
    .inc   (pc_inc),
    .pc    (pc)
  );

  assign imem_addr = pc;
  assign reg_x     = ir[RX_MSB:RX_LSB];
  assign reg_y     = ir[RY_MSB:RY_LSB];
  assign rdata_op  = imem_rdata[OPC_MSB:OPC_LSB];
  assign issue_op  = ir_load ? rdata_op : ir[OPC_MSB:OPC_LSB];

  // Next state; entries into ISSUE stall in place (no pc/IR update) until the control unit is idle.
  always_comb begin
    state_d  = state;
    pc_inc   = 1'b0;
    ir_load  = 1'b0;
    imm_load = 1'b0;
    case (state)
      IDLE:    if (run) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE: begin
        if (rdata_op == OP_MOVI) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = IMM_REQ;
        end else if (rdata_op == OP_NONE) begin
`ifdef INSTRUCTION_FETCH_HALT_OPCODE_EN
          state_d = HALTED;
`else
          pc_inc  = 1'b1;
          state_d = FETCH;
`endif
        end else if (done) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ISSUE;
        end
      end
      IMM_REQ: state_d = IMM_CAP;
      IMM_CAP: begin
        if (done) begin
          imm_load = 1'b1;
          pc_inc   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (done) state_d = run ? FETCH : IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ir        <= '0;
      immediate <= '0;
      opcode    <= OP_NONE;
      busy      <= 1'b0;
`ifdef INSTRUCTION_FETCH_HALT_OPCODE_EN
      halted    <= 1'b0;
`endif
    end else begin
      state <= state_d;
      if (ir_load)  ir        <= imem_rdata;
      if (imm_load) immediate <= imem_rdata;
      opcode <= (state_d == ISSUE) ? issue_op : OP_NONE;
      busy   <= (state_d != IDLE) && (state_d != HALTED);
`ifdef INSTRUCTION_FETCH_HALT_OPCODE_EN
      halted <= (state_d == HALTED);
`endif
    end
  end

endmodule
